// File: rtl/vdma_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vdma_pkg
// Description : Shared types and constants for the VDMA AXI burst writer:
//               FSM state encoding, AXI burst/response codes and the
//               maximum burst length in beats.
// Revision    : 1.0  initial release
// ============================================================================
package vdma_pkg;

  // Write-master FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_BRESP = 3'd3,
    ST_ZERO  = 3'd4
  } state_t;

  // AXI4 encodings
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Largest INCR burst AXI4 allows, in beats
  localparam int MAX_BURST = 256;

endpackage : vdma_pkg
`default_nettype wire

// File: rtl/vdma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vdma_addr_gen
// Description : Frame-relative write address generator. Holds the current
//               burst address, advances it by len*BYTES after each burst,
//               wraps to base_addr at the end of the frame and handles the
//               frame-restart request.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   clock
//   rst          in   asynchronous active-high reset
//   base_addr    in   frame base address (BYTES-aligned)
//   frame_bytes  in   frame size in bytes
//   frame_start  in   pulse: restart addressing at base_addr
//   len          in   beats of the burst in flight
//   accept       in   pulse: a request is being accepted this cycle
//   advance      in   pulse: burst completed, move to the next address
//   idle_entry   in   pulse: FSM returns to IDLE this cycle
//   cur_addr     out  address to use for the next accepted burst
// ============================================================================
module vdma_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LSIZE  = 9
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_bytes,
  input  logic              frame_start,
  input  logic [LSIZE-1:0]  len,
  input  logic              accept,
  input  logic              advance,
  input  logic              idle_entry,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam int SHIFT = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] addr_q;
  logic              restart_pend_q;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] frame_end;
  logic [ADDR_W-1:0] wrapped;

  always_comb begin
    // A pending restart redirects the very next burst to the frame base,
    // which also covers the first burst after reset (no IDLE entry occurs).
    cur_addr  = restart_pend_q ? base_addr : addr_q;
    step      = ADDR_W'(len) << SHIFT;
    next_addr = addr_q + step;
    frame_end = base_addr + frame_bytes;
    wrapped   = (next_addr >= frame_end) ? base_addr : next_addr;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      restart_pend_q <= 1'b1;
    end else begin
      if (accept) begin
        // Latch the address actually used so the advance is relative to it
        addr_q         <= cur_addr;
        restart_pend_q <= frame_start;
      end else if (idle_entry && restart_pend_q) begin
        // Restart wins over the normal advance
        addr_q         <= base_addr;
        restart_pend_q <= frame_start;
      end else begin
        if (advance) begin
          addr_q <= wrapped;
        end
        if (frame_start) begin
          restart_pend_q <= 1'b1;
        end
      end
    end
  end

endmodule : vdma_addr_gen
`default_nettype wire

// File: rtl/vdma_axi_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : vdma_axi_burst_writer
// Description : AXI4 write master for the VDMA write path. Accepts burst/tail
//               requests, drains exactly len words from an FWFT line FIFO
//               into one INCR burst and reports completion on the B response.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, rst                       clock, async active-high reset
//   base_addr, frame_bytes           frame geometry
//   frame_start                      restart addressing at base_addr
//   burst_req, tail_req, req_len     request from the FIFO status controller
//   resp, done                       accept / completion pulses
//   fifo_rdata, fifo_empty, fifo_rd_en   FWFT FIFO read side
//   aw*, w*, b*                      AXI4 write address/data/response channels
//   wr_err                           sticky error (bad bresp or clamped len)
// ============================================================================
module vdma_axi_burst_writer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int LSIZE     = 9,
  parameter int MAX_BURST = vdma_pkg::MAX_BURST
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   frame_bytes,
  input  logic                frame_start,
  input  logic                burst_req,
  input  logic                tail_req,
  input  logic [LSIZE-1:0]    req_len,
  output logic                resp,
  output logic                done,
  input  logic [DATA_W-1:0]   fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                wr_err
);

  import vdma_pkg::*;

  localparam int               BYTES   = DATA_W / 8;
  localparam logic [2:0]       AWSIZE  = 3'($clog2(BYTES));
  localparam logic [LSIZE-1:0] MAX_LEN = LSIZE'(MAX_BURST);

  state_t             state_q;
  logic [LSIZE-1:0]   len_q;
  logic [LSIZE-1:0]   beat_q;
  logic [ADDR_W-1:0]  awaddr_q;
  logic [7:0]         awlen_q;
  logic               awvalid_q;
  logic               bready_q;
  logic               resp_q;
  logic               done_q;
  logic               wr_err_q;

  logic               req;
  logic               clamp;
  logic [LSIZE-1:0]   len_clamped;
  logic               in_data;
  logic               w_hs;
  logic               last_beat;
  logic               b_hs;
  logic               accept;
  logic               idle_entry;
  logic [ADDR_W-1:0]  cur_addr;

  always_comb begin
    // burst_req and tail_req behave identically once accepted
    req         = burst_req | tail_req;
    clamp       = req_len > MAX_LEN;
    len_clamped = clamp ? MAX_LEN : req_len;
    in_data     = (state_q == ST_DATA);
    w_hs        = in_data & ~fifo_empty & wready;
    last_beat   = (beat_q == (len_q - LSIZE'(1)));
    b_hs        = (state_q == ST_BRESP) & bvalid;
    accept      = (state_q == ST_IDLE) & req;
    idle_entry  = b_hs | (state_q == ST_ZERO);
  end

  vdma_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LSIZE  (LSIZE)
  ) u_addr_gen (
    .clock       (clock),
    .rst         (rst),
    .base_addr   (base_addr),
    .frame_bytes (frame_bytes),
    .frame_start (frame_start),
    .len         (len_q),
    .accept      (accept),
    .advance     (b_hs),
    .idle_entry  (idle_entry),
    .cur_addr    (cur_addr)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      resp_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            resp_q <= 1'b1;
            len_q  <= len_clamped;
            beat_q <= '0;
            if (clamp) begin
              wr_err_q <= 1'b1;
            end
            if (len_clamped == '0) begin
              state_q <= ST_ZERO;
            end else begin
              awaddr_q  <= cur_addr;
              awlen_q   <= 8'(len_clamped - LSIZE'(1));
              awvalid_q <= 1'b1;
              state_q   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + LSIZE'(1);
            if (last_beat) begin
              bready_q <= 1'b1;
              state_q  <= ST_BRESP;
            end
          end
        end
        ST_BRESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            if (bresp != RESP_OKAY) begin
              wr_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        ST_ZERO: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // W channel follows the FWFT head directly; gating by state keeps every
  // data-path output at zero outside DATA (including during reset).
  always_comb begin
    resp       = resp_q;
    done       = done_q;
    awaddr     = awaddr_q;
    awlen      = awlen_q;
    awsize     = AWSIZE;
    awburst    = BURST_INCR;
    awvalid    = awvalid_q;
    wvalid     = in_data & ~fifo_empty;
    wdata      = in_data ? fifo_rdata : '0;
    wstrb      = in_data ? '1 : '0;
    wlast      = in_data & last_beat;
    fifo_rd_en = w_hs;
    bready     = bready_q;
    wr_err     = wr_err_q;
  end

endmodule : vdma_axi_burst_writer
`default_nettype wire
